// File: rtl/sfx_trigger_scheduler.sv
// sfx_trigger_scheduler
// Queues one-cycle sound-effect requests and replays them as stretched,
// rate-limited trigger pulses for the jump/score/death tone generators.
//
// Ports:
//   clock, reset            system clock, synchronous active-high reset
//   req_valid, req_code     request strobe and code (0=jump, 1=score, 2=death)
//   clear_flags             clears the sticky overflow/illegal flags
//   trig_jump/score/death   registered trigger pulses, PULSE_CYCLES wide
//   ch_holdoff              per-channel retrigger holdoff active (bit i = code i)
//   pending                 request FIFO occupancy
//   overflow, illegal       sticky: request dropped on full FIFO / code > 2
//
// Build option: define SFX_DEATH_PREEMPT_EN to let a death request flush the
// queue and abort any pulse in progress. It is disabled by default.
module sfx_trigger_scheduler #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned PULSE_CYCLES   = 8,
    parameter int unsigned HOLDOFF_CYCLES = 1024,
    parameter int unsigned CW             = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [31:0]              req_code,
    input  logic                     clear_flags,
    output logic                     trig_jump,
    output logic                     trig_score,
    output logic                     trig_death,
    output logic [2:0]               ch_holdoff,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     overflow,
    output logic                     illegal
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic {S_IDLE, S_PULSE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      fifo_q [DEPTH];
    logic [1:0]      fifo_d [DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   pulse_q, pulse_d;
    logic [CW-1:0]   hold_q [3];
    logic [CW-1:0]   hold_d [3];
    logic [2:0]      trig_q, trig_d;
    logic            overflow_q, overflow_d;
    logic            illegal_q, illegal_d;

    logic [PW-1:0]   count_c;
    logic            full_c, empty_c;
    logic [1:0]      head_c;
    logic            head_free_c;
    logic            req_legal_c, req_bad_c, death_c;
    logic            pop_c, push_c, drop_c;

    // Request decode and FIFO status
    assign req_legal_c = req_valid && (req_code < 32'd3);
    assign req_bad_c   = req_valid && (req_code > 32'd2);
    assign count_c     = wr_q - rd_q;
    assign full_c      = (count_c == PW'(DEPTH));
    assign empty_c     = (wr_q == rd_q);
    assign head_c      = fifo_q[rd_q[AW-1:0]];

`ifdef SFX_DEATH_PREEMPT_EN
    assign death_c = req_valid && (req_code == 32'd2);
`else
    assign death_c = 1'b0;
`endif

    // A counter at 1 expires on this edge, so the channel may relaunch now;
    // this keeps rising edges exactly HOLDOFF_CYCLES apart.
    always_comb begin
        head_free_c = 1'b0;
        case (head_c)
            2'd0:    head_free_c = (hold_q[0] <= CW'(1));
            2'd1:    head_free_c = (hold_q[1] <= CW'(1));
            2'd2:    head_free_c = (hold_q[2] <= CW'(1));
            default: head_free_c = 1'b0;
        endcase
    end

    assign pop_c  = (state_q == S_IDLE) && !empty_c && head_free_c && !death_c;
    assign push_c = req_legal_c && !death_c && (!full_c || pop_c);
    assign drop_c = req_legal_c && !death_c && full_c && !pop_c;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (death_c) begin
            state_d = S_PULSE;
        end else begin
            case (state_q)
                S_IDLE:  if (pop_c) state_d = S_PULSE;
                S_PULSE: if (pulse_q == CW'(1)) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs, FIFO and counters
    always_comb begin
        fifo_d     = fifo_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        pulse_d    = pulse_q;
        trig_d     = trig_q;
        overflow_d = (overflow_q && !clear_flags) || drop_c;
        illegal_d  = (illegal_q && !clear_flags) || req_bad_c;
        for (int i = 0; i < 3; i++) begin
            hold_d[i] = (hold_q[i] != '0) ? hold_q[i] - CW'(1) : '0;
        end

        if (push_c) begin
            fifo_d[wr_q[AW-1:0]] = req_code[1:0];
            wr_d                 = wr_q + PW'(1);
        end
        if (pop_c) rd_d = rd_q + PW'(1);

        case (state_q)
            S_IDLE: begin
                if (pop_c) begin
                    pulse_d = CW'(PULSE_CYCLES);
                    trig_d  = 3'(3'b001 << head_c);
                    for (int i = 0; i < 3; i++) begin
                        if (head_c == 2'(i)) hold_d[i] = CW'(HOLDOFF_CYCLES);
                    end
                end
            end
            S_PULSE: begin
                pulse_d = pulse_q - CW'(1);
                if (pulse_q == CW'(1)) trig_d = 3'b000;
            end
            default: trig_d = 3'b000;
        endcase

        // Death preemption overrides everything queued or in flight
        if (death_c) begin
            rd_d      = wr_q;
            pulse_d   = CW'(PULSE_CYCLES);
            trig_d    = 3'b100;
            hold_d[2] = CW'(HOLDOFF_CYCLES);
        end
    end

    // Datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
            for (int i = 0; i < 3; i++) hold_q[i] <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            pulse_q    <= '0;
            trig_q     <= '0;
            overflow_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            fifo_q     <= fifo_d;
            hold_q     <= hold_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            pulse_q    <= pulse_d;
            trig_q     <= trig_d;
            overflow_q <= overflow_d;
            illegal_q  <= illegal_d;
        end
    end

    assign trig_jump  = trig_q[0];
    assign trig_score = trig_q[1];
    assign trig_death = trig_q[2];
    assign ch_holdoff = {hold_q[2] != '0, hold_q[1] != '0, hold_q[0] != '0};
    assign pending    = count_c;
    assign overflow   = overflow_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_sfx_trigger_scheduler.sv
// Directed bench for sfx_trigger_scheduler with DEPTH=4, PULSE_CYCLES=8,
// HOLDOFF_CYCLES=1024. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point, so "cycle N+k" is the k-th step
// after the request was presented.
module tb_sfx_trigger_scheduler;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_code;
    logic        clear_flags;
    logic        trig_jump, trig_score, trig_death;
    logic [2:0]  ch_holdoff;
    logic [2:0]  pending;
    logic        overflow, illegal;

    int checks = 0;
    int passed = 0;

    sfx_trigger_scheduler #(
        .DEPTH(4), .PULSE_CYCLES(8), .HOLDOFF_CYCLES(1024), .CW(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_code   (req_code),
        .clear_flags(clear_flags),
        .trig_jump  (trig_jump),
        .trig_score (trig_score),
        .trig_death (trig_death),
        .ch_holdoff (ch_holdoff),
        .pending    (pending),
        .overflow   (overflow),
        .illegal    (illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one cycle, ending one cycle later
    task automatic req(input logic [31:0] code);
        req_valid = 1'b1;
        req_code  = code;
        step();
        req_valid = 1'b0;
        req_code  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({trig_jump, trig_score, trig_death} !== 3'b000)
            $display("FAIL reset_trig got=%b want=000", {trig_jump, trig_score, trig_death});
        else passed++;
        checks++;
        if (ch_holdoff !== 3'b000) $display("FAIL reset_holdoff got=%b want=000", ch_holdoff);
        else passed++;
        checks++;
        if ({pending, overflow, illegal} !== 5'd0)
            $display("FAIL reset_status got pending=%0d ovf=%b ill=%b want 0/0/0", pending, overflow, illegal);
        else passed++;
    endtask

    task automatic test_single_jump();
        int hi;
        do_reset();
        req(32'd0);                                   // now N+1
        checks++;
        if (pending !== 3'd1 || trig_jump !== 1'b0)
            $display("FAIL jump_n1 got pending=%0d trig=%b want 1/0", pending, trig_jump);
        else passed++;
        step();                                       // N+2
        checks++;
        if (trig_jump !== 1'b1 || ch_holdoff !== 3'b001 || pending !== 3'd0)
            $display("FAIL jump_n2 got trig=%b hold=%b pending=%0d want 1/001/0", trig_jump, ch_holdoff, pending);
        else passed++;
        hi = 1;
        for (int k = 3; k <= 9; k++) begin
            step();
            if (trig_jump === 1'b1) hi++;
        end
        step();                                       // N+10
        checks++;
        if (trig_jump !== 1'b0 || hi != 8)
            $display("FAIL jump_width got high_cycles=%0d trig_n10=%b want 8/0", hi, trig_jump);
        else passed++;
        repeat (1015) step();                         // N+1025
        checks++;
        if (ch_holdoff !== 3'b001) $display("FAIL holdoff_last got=%b want=001", ch_holdoff);
        else passed++;
        step();                                       // N+1026
        checks++;
        if (ch_holdoff !== 3'b000) $display("FAIL holdoff_expire got=%b want=000", ch_holdoff);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_t;
        int errs;
        do_reset();
        req(32'd0);                                   // N+1
        req(32'd1);                                   // N+2
        checks++;
        if (pending !== 3'd1 || trig_jump !== 1'b1)
            $display("FAIL b2b_n2 got pending=%0d trig_jump=%b want 1/1", pending, trig_jump);
        else passed++;
        req(32'd2);                                   // N+3
        checks++;
        if (pending !== 3'd2) $display("FAIL b2b_peak got pending=%0d want 2", pending);
        else passed++;
        errs = 0;
        for (int c = 3; c <= 29; c++) begin
            exp_t = (c >= 2  && c <= 9)  ? 3'b001 :
                    (c >= 11 && c <= 18) ? 3'b010 :
                    (c >= 20 && c <= 27) ? 3'b100 : 3'b000;
            if ({trig_death, trig_score, trig_jump} !== exp_t) begin
                if (errs == 0)
                    $display("FAIL b2b_seq cycle N+%0d got=%b want=%b", c, {trig_death, trig_score, trig_jump}, exp_t);
                errs++;
            end
            if (c < 29) step();
        end
        checks++;
        if (errs != 0) $display("FAIL b2b_seq_total got %0d bad cycles want 0", errs);
        else passed++;
    endtask

    task automatic test_holdoff_spacing();
        int bad;
        do_reset();
        req(32'd0);                                   // N+1
        req(32'd0);                                   // N+2
        checks++;
        if (trig_jump !== 1'b1 || pending !== 3'd1)
            $display("FAIL space_n2 got trig=%b pending=%0d want 1/1", trig_jump, pending);
        else passed++;
        bad = 0;
        for (int c = 3; c <= 1025; c++) begin
            step();
            if (pending !== 3'd1) bad++;
        end
        checks++;
        if (bad != 0 || trig_jump !== 1'b0)
            $display("FAIL space_wait got bad_pending=%0d trig_n1025=%b want 0/0", bad, trig_jump);
        else passed++;
        step();                                       // N+1026
        checks++;
        if (trig_jump !== 1'b1 || pending !== 3'd0)
            $display("FAIL space_rise got trig=%b pending=%0d want 1/0", trig_jump, pending);
        else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        req(32'd0);                                   // N+1
        repeat (9) step();                            // N+10, jump pulse over
        req(32'd0);                                   // blocked head
        for (int i = 0; i < 6; i++) req(32'd1);
        checks++;
        if (pending !== 3'd4 || overflow !== 1'b1 || ch_holdoff !== 3'b001)
            $display("FAIL ovf_set got pending=%0d ovf=%b hold=%b want 4/1/001", pending, overflow, ch_holdoff);
        else passed++;
        clear_flags = 1'b1;
        step();
        clear_flags = 1'b0;
        checks++;
        if (overflow !== 1'b0 || pending !== 3'd4)
            $display("FAIL ovf_clear got ovf=%b pending=%0d want 0/4", overflow, pending);
        else passed++;

        // Full FIFO with a pop in the same cycle accepts the request
        do_reset();
        req(32'd0);                                   // N+1
        for (int i = 0; i < 4; i++) req(32'd1);       // N+5
        checks++;
        if (pending !== 3'd4) $display("FAIL full_fill got pending=%0d want 4", pending);
        else passed++;
        repeat (5) step();                            // N+10, IDLE with free score head
        req(32'd1);                                   // N+11
        checks++;
        if (pending !== 3'd4 || overflow !== 1'b0 || trig_score !== 1'b1)
            $display("FAIL full_pop got pending=%0d ovf=%b trig_score=%b want 4/0/1", pending, overflow, trig_score);
        else passed++;
    endtask

    task automatic test_illegal_and_reset();
        int trig_seen;
        do_reset();
        req(32'd7);
        checks++;
        if (illegal !== 1'b1 || pending !== 3'd0)
            $display("FAIL illegal_set got ill=%b pending=%0d want 1/0", illegal, pending);
        else passed++;
        trig_seen = 0;
        repeat (4) begin
            step();
            if (trig_jump | trig_score | trig_death) trig_seen++;
        end
        checks++;
        if (trig_seen != 0) $display("FAIL illegal_notrig got %0d trigger cycles want 0", trig_seen);
        else passed++;
        clear_flags = 1'b1;
        req(32'd3);
        checks++;
        if (illegal !== 1'b1) $display("FAIL illegal_setwins got=%b want=1", illegal);
        else passed++;
        step();
        clear_flags = 1'b0;
        checks++;
        if (illegal !== 1'b0) $display("FAIL illegal_clear got=%b want=0", illegal);
        else passed++;

        // Reset in the middle of a pulse
        req(32'd1);
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if ({trig_jump, trig_score, trig_death, ch_holdoff, pending, overflow, illegal} !== 11'd0)
            $display("FAIL reset_midpulse got trig=%b hold=%b pending=%0d ovf=%b ill=%b want all 0",
                     {trig_jump, trig_score, trig_death}, ch_holdoff, pending, overflow, illegal);
        else passed++;
        reset = 1'b0;
    endtask

    task automatic test_death();
        do_reset();
        req(32'd0);                                   // N+1
        req(32'd1);                                   // N+2
        req(32'd0);                                   // N+3, jump pulsing, 2 queued
        checks++;
        if (trig_jump !== 1'b1 || pending !== 3'd2)
            $display("FAIL death_setup got trig_jump=%b pending=%0d want 1/2", trig_jump, pending);
        else passed++;
        req(32'd2);                                   // N+4
`ifdef SFX_DEATH_PREEMPT_EN
        checks++;
        if (trig_jump !== 1'b0 || trig_death !== 1'b1 || pending !== 3'd0 || ch_holdoff[2] !== 1'b1)
            $display("FAIL death_preempt got jump=%b death=%b pending=%0d hold2=%b want 0/1/0/1",
                     trig_jump, trig_death, pending, ch_holdoff[2]);
        else passed++;
        repeat (7) step();                            // N+11, last death cycle
        checks++;
        if (trig_death !== 1'b1) $display("FAIL death_width got=%b want=1", trig_death);
        else passed++;
        step();
        checks++;
        if ({trig_jump, trig_score, trig_death} !== 3'b000 || pending !== 3'd0)
            $display("FAIL death_after got trig=%b pending=%0d want 000/0", {trig_jump, trig_score, trig_death}, pending);
        else passed++;
`else
        checks++;
        if (trig_jump !== 1'b1 || trig_death !== 1'b0 || pending !== 3'd3)
            $display("FAIL death_queued got jump=%b death=%b pending=%0d want 1/0/3", trig_jump, trig_death, pending);
        else passed++;
        repeat (7) step();                            // N+11
        checks++;
        if (trig_score !== 1'b1 || pending !== 3'd2)
            $display("FAIL death_order_score got score=%b pending=%0d want 1/2", trig_score, pending);
        else passed++;
        repeat (9) step();                            // N+20, jump head blocked, death behind it
        checks++;
        if ({trig_jump, trig_score, trig_death} !== 3'b000 || pending !== 3'd2)
            $display("FAIL death_waits got trig=%b pending=%0d want 000/2", {trig_jump, trig_score, trig_death}, pending);
        else passed++;
`endif
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_code    = '0;
        clear_flags = 1'b0;
        test_reset();
        test_single_jump();
        test_back_to_back();
        test_holdoff_spacing();
        test_overflow();
        test_illegal_and_reset();
        test_death();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
